// File: rtl/y86_bus_mem.sv
// Unified byte-addressed instruction/data memory for the y86 core bus, with a memory-mapped console FIFO.
// Define Y86_CONSOLE_EN to build the console; without it CON_ADDR is just an out-of-range RAM address.
module y86_bus_mem #(
  parameter int unsigned AW        = 12,
  parameter logic [31:0] CON_ADDR  = 32'hFFFF_FFF0,
  parameter int unsigned CON_DEPTH = 8,
  parameter string       INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] bus_A,
  input  logic        bus_RE,
  input  logic        bus_WE,
  input  logic [31:0] bus_out,
  output logic [31:0] bus_in,
  output logic        con_valid,
  output logic [7:0]  con_data,
  input  logic        con_ready,
  output logic        con_ovf,
  output logic        addr_err
);

  localparam int unsigned MEM_BYTES = 2 ** AW;
  localparam int unsigned PW        = (CON_DEPTH > 1) ? $clog2(CON_DEPTH) : 1;
  localparam int unsigned CW        = PW + 1;

  logic [7:0]    mem [MEM_BYTES];
  logic [AW-1:0] a_c;
  logic          is_con_c;
  logic          oor_c;
  logic [15:0]   con_status_c;
  logic          err_q, err_d;

  assign a_c   = bus_A[AW-1:0];
  assign oor_c = ((bus_A >> AW) != 32'd0) && !is_con_c;

  // Zero-latency read: the core samples bus_in at the edge ending its fetch/memory state.
  always_comb begin
    bus_in = '0;
    if (bus_RE) begin
      if (is_con_c) begin
        bus_in = {16'b0, con_status_c};
      end else begin
        for (int i = 0; i < 4; i++) begin
          bus_in[8*i +: 8] = mem[a_c + AW'(i)];
        end
      end
    end
  end

  // RAM is deliberately outside reset so a write in the reset cycle still lands.
  always_ff @(posedge clk) begin
    if (bus_WE && !is_con_c) begin
      for (int i = 0; i < 4; i++) begin
        mem[a_c + AW'(i)] <= bus_out[8*i +: 8];
      end
    end
  end

  always_comb begin
    err_d = err_q | ((bus_RE | bus_WE) & oor_c);
  end

  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign addr_err = err_q;

`ifdef Y86_CONSOLE_EN
  logic [7:0]    fifo_q [CON_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          valid_q, valid_d;
  logic [7:0]    data_q, data_d;
  logic          full_c, empty_c, push_c, pop_c, accept_c;

  assign is_con_c     = (bus_A == CON_ADDR);
  assign con_status_c = {8'(count_q), 6'b0, full_c, empty_c};

  // A pop frees a slot in the same cycle, so push+pop on a full FIFO is accepted.
  always_comb begin
    full_c   = (count_q == CW'(CON_DEPTH));
    empty_c  = (count_q == '0);
    push_c   = bus_WE && is_con_c;
    pop_c    = !empty_c && con_ready;
    accept_c = push_c && (!full_c || pop_c);
    wr_ptr_d = wr_ptr_q + PW'(accept_c);
    rd_ptr_d = rd_ptr_q + PW'(pop_c);
    count_d  = count_q + CW'(accept_c) - CW'(pop_c);
    ovf_d    = ovf_q | (push_c && full_c && !pop_c);
    valid_d  = (count_d != '0);
    data_d   = 8'h00;
    if (count_d != '0) begin
      if (accept_c && (wr_ptr_q == rd_ptr_d)) data_d = bus_out[7:0];
      else                                    data_d = fifo_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      valid_q  <= 1'b0;
      data_q   <= 8'h00;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
      if (accept_c) fifo_q[wr_ptr_q] <= bus_out[7:0];
    end
  end

  assign con_valid = valid_q;
  assign con_data  = data_q;
  assign con_ovf   = ovf_q;
`else
  logic unused_con;

  assign is_con_c     = 1'b0;
  assign con_status_c = 16'h0000;
  assign unused_con   = ^{con_ready, CON_ADDR, 1'(CON_DEPTH)};
  assign con_valid    = 1'b0;
  assign con_data     = 8'h00;
  assign con_ovf      = 1'b0;
`endif

endmodule

// File: tb/tb_y86_bus_mem.sv
// Self-checking bench for y86_bus_mem: directed plan steps plus random traffic against a queue/array model.
module tb_y86_bus_mem;

  localparam int unsigned AW    = 12;
  localparam int unsigned DEPTH = 8;
  localparam logic [31:0] CON   = 32'hFFFF_FFF0;
`ifdef Y86_CONSOLE_EN
  localparam bit CON_EN = 1'b1;
`else
  localparam bit CON_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, re, we, rdy;
  logic [31:0] a, dout;
  logic [31:0] bus_in;
  logic        con_valid, con_ovf, addr_err;
  logic [7:0]  con_data;

  int errors = 0;
  int checks = 0;

  logic [7:0] mem_m [2**AW];
  logic [7:0] q_m [$];
  logic       ovf_m = 1'b0;
  logic       err_m = 1'b0;

  y86_bus_mem #(.AW(AW), .CON_ADDR(CON), .CON_DEPTH(DEPTH), .INIT_FILE("")) dut (
    .clk(clk), .rst(rst), .bus_A(a), .bus_RE(re), .bus_WE(we), .bus_out(dout),
    .bus_in(bus_in), .con_valid(con_valid), .con_data(con_data), .con_ready(rdy),
    .con_ovf(con_ovf), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_read(input logic r, input logic [31:0] ad);
    logic [31:0]   v;
    logic [AW-1:0] b;
    v = 32'h0;
    if (!r) return v;
    if (CON_EN && ad == CON)
      return {16'h0, 8'(q_m.size()), 6'h0, q_m.size() == DEPTH, q_m.size() == 0};
    for (int i = 0; i < 4; i++) begin
      b = ad[AW-1:0] + AW'(i);
      v[8*i +: 8] = mem_m[b];
    end
    return v;
  endfunction

  // One bus cycle: check the combinational read, advance the model, then check registered outputs.
  task automatic cycle(input logic r, input logic w, input logic [31:0] ad, input logic [31:0] d,
                       input logic rd, input logic rs);
    logic          con_hit, oor, pop, was_full;
    logic [AW-1:0] b;
    re = r; we = w; a = ad; dout = d; rdy = rd; rst = rs;
    #1;
    chk("bus_in", bus_in, exp_read(r, ad));
    con_hit = CON_EN && (ad == CON);
    oor     = ((ad >> AW) != 0) && !con_hit;
    if (w && !con_hit) begin
      for (int i = 0; i < 4; i++) begin
        b = ad[AW-1:0] + AW'(i);
        mem_m[b] = d[8*i +: 8];
      end
    end
    if (rs) begin
      q_m.delete();
      ovf_m = 1'b0;
      err_m = 1'b0;
    end else begin
      was_full = (q_m.size() == DEPTH);
      pop      = (q_m.size() != 0) && rd;
      if (pop) void'(q_m.pop_front());
      if (w && con_hit) begin
        if (!was_full || pop) q_m.push_back(d[7:0]);
        else                  ovf_m = 1'b1;
      end
      if ((r || w) && oor) err_m = 1'b1;
    end
    @(posedge clk);
    #1;
    chk("con_valid", 32'(con_valid), 32'(q_m.size() != 0));
    chk("con_data", 32'(con_data), (q_m.size() != 0) ? 32'(q_m[0]) : 32'h0);
    chk("con_ovf", 32'(con_ovf), 32'(ovf_m));
    chk("addr_err", 32'(addr_err), 32'(err_m));
  endtask

  // Combinational read probe with a fixed expectation, no clock edge.
  task automatic peek(input string tag, input logic [31:0] ad, input logic [31:0] mask,
                      input logic [31:0] exp);
    re = 1'b1; we = 1'b0; a = ad; rst = 1'b0;
    #1;
    chk(tag, bus_in & mask, exp);
    chk({tag, "_model"}, bus_in, exp_read(1'b1, ad));
  endtask

  initial begin
    logic [31:0] ad;
    int unsigned k;
    re = 0; we = 0; a = 0; dout = 0; rdy = 0; rst = 1;

    cycle(0, 0, 32'h0, 32'h0, 0, 1);
    cycle(0, 0, 32'h0, 32'h0, 0, 1);

    // Give every RAM byte a known value.
    for (int i = 0; i < (2**AW) / 4; i++) cycle(0, 1, 32'(4 * i), $urandom(), 0, 0);

    // Unaligned fetch.
    cycle(0, 1, 32'h0, 32'h8901_458B, 0, 0);
    cycle(0, 1, 32'h4, 32'h0000_74C3, 0, 0);
    peek("unaligned", 32'h1, 32'hFFFF_FFFF, 32'hC389_0145);
    cycle(1, 0, 32'h1, 32'h0, 0, 0);

    // Write then read, aligned and half-offset.
    cycle(0, 1, 32'h10, 32'hDEAD_BEEF, 0, 0);
    peek("wr_rd", 32'h10, 32'hFFFF_FFFF, 32'hDEAD_BEEF);
    peek("wr_rd_off", 32'h12, 32'h0000_FFFF, 32'h0000_DEAD);
    cycle(1, 1, 32'h10, 32'h0102_0304, 0, 0);
    peek("rmw_new", 32'h10, 32'hFFFF_FFFF, 32'h0102_0304);

    // Address wrap at the top of RAM.
    cycle(0, 1, 32'hFFF, 32'h1122_3344, 0, 0);
    peek("wrap", 32'hFFF, 32'hFFFF_FFFF, 32'h1122_3344);
    peek("wrap_low", 32'h0, 32'h00FF_FFFF, 32'h0011_2233);
    cycle(1, 0, 32'h0, 32'h0, 0, 0);

    // Console: two bytes, status read, then drain.
    cycle(0, 1, CON, 32'h48, 0, 0);
    cycle(0, 1, CON, 32'h69, 0, 0);
    cycle(1, 0, CON, 32'h0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 32'h0, 32'h0, 1, 0);

    // Overflow: nine pushes, then push+pop while full.
    for (int i = 0; i < 9; i++) cycle(0, 1, CON, 32'(8'hA0 + i), 0, 0);
    cycle(1, 0, CON, 32'h0, 0, 0);
    cycle(1, 1, CON, 32'hBB, 1, 0);
    cycle(1, 0, CON, 32'h0, 0, 0);

    // Out-of-range write aliases to M[0]; then reset with bytes queued and a RAM write in flight.
    cycle(0, 1, 32'h0001_0000, 32'h5566_7788, 0, 0);
    peek("oor_alias", 32'h0, 32'hFFFF_FFFF, 32'h5566_7788);
    cycle(0, 0, 32'h0, 32'h0, 0, 1);
    for (int i = 0; i < 3; i++) cycle(0, 1, CON, 32'(8'h30 + i), 0, 0);
    cycle(0, 1, 32'h20, 32'hCAFE_F00D, 0, 1);
    peek("reset_ram", 32'h20, 32'hFFFF_FFFF, 32'hCAFE_F00D);
    cycle(1, 0, 32'h0, 32'h0, 1, 0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      k = $urandom_range(0, 15);
      if (k < 4) ad = CON;
      else if (k == 4) begin
        ad = $urandom();
        if ((ad >> AW) == 0) ad = ad | 32'h0000_1000;
      end else ad = 32'($urandom_range(0, 2**AW - 1));
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ad, $urandom(),
            1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 99) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
